// File: rtl/router_in_port.sv
// Router ingress port: deserializes the 4-byte node->router transfer into a packet FIFO
// and presents the head packet over valid/ready. Optional framing checks: ROUTER_IN_PORT_ERRCHK_EN.
//
// state | meaning
// IDLE  | waiting for a header byte {src,dest}
// B1    | header captured, expecting data[23:16]
// B2    | expecting data[15:8]
// B3    | expecting data[7:0]; packet pushed on that byte
module router_in_port #(
    parameter int DEPTH   = 4,
    parameter int PORT_ID = 0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        free_outbound,
    input  logic        put_outbound,
    input  logic [7:0]  payload_outbound,
    output logic [31:0] pkt_out,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [3:0]  pkt_port,
    output logic        framing_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        B3   = 2'd3
    } rx_state_t;

    rx_state_t     state;
    rx_state_t     next_state;
    logic [7:0]    hdr_q;
    logic [7:0]    data_hi_q;
    logic [7:0]    data_mid_q;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          free_next;
    logic [31:0]   rx_pkt;
`ifdef ROUTER_IN_PORT_ERRCHK_EN
    logic          err_next;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign pkt_valid   = (count != '0);
    assign pop         = pkt_valid && pkt_ready;
    assign rx_pkt      = {hdr_q, data_hi_q, data_mid_q, payload_outbound};
    assign pkt_port    = 4'(PORT_ID);
    assign count_next  = count + CW'(push) - CW'(pop);
    assign rd_ptr_next = pop ? ptr_inc(rd_ptr) : rd_ptr;
    assign free_next   = (next_state == IDLE) && (count_next < DEPTH_C);

    always_comb begin
        next_state = state;
        push       = 1'b0;
`ifdef ROUTER_IN_PORT_ERRCHK_EN
        err_next   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (put_outbound && free_outbound) next_state = B1;
`ifdef ROUTER_IN_PORT_ERRCHK_EN
                else if (put_outbound) err_next = 1'b1;
`endif
            end
            B1: begin
                if (put_outbound) next_state = B2;
`ifdef ROUTER_IN_PORT_ERRCHK_EN
                else begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                end
`endif
            end
            B2: begin
                if (put_outbound) next_state = B3;
`ifdef ROUTER_IN_PORT_ERRCHK_EN
                else begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                end
`endif
            end
            B3: begin
                if (put_outbound) begin
                    next_state = IDLE;
                    push       = 1'b1;
                end
`ifdef ROUTER_IN_PORT_ERRCHK_EN
                else begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                end
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hdr_q         <= '0;
            data_hi_q     <= '0;
            data_mid_q    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            free_outbound <= 1'b0;
            pkt_out       <= '0;
        end else begin
            state         <= next_state;
            count         <= count_next;
            rd_ptr        <= rd_ptr_next;
            free_outbound <= free_next;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (state == IDLE && put_outbound && free_outbound) hdr_q <= payload_outbound;
            if (state == B1 && put_outbound) data_hi_q  <= payload_outbound;
            if (state == B2 && put_outbound) data_mid_q <= payload_outbound;
            // Registered head: a packet pushed into an empty (or draining-to-empty) FIFO
            // is not in mem yet, so it is taken straight from the assembly bytes.
            if (count_next != '0) begin
                pkt_out <= (push && wr_ptr == rd_ptr_next) ? rx_pkt : mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= rx_pkt;
    end

`ifdef ROUTER_IN_PORT_ERRCHK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) framing_err <= 1'b0;
        else       framing_err <= err_next;
    end
`else
    assign framing_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_in_port.sv
// Bench for router_in_port: directed scenarios plus random traffic, every cycle compared
// against a packet-queue reference model. Follows ROUTER_IN_PORT_ERRCHK_EN if defined.
module tb_router_in_port;

    localparam int DEPTH = 4;
`ifdef ROUTER_IN_PORT_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        put_outbound = 1'b0;
    logic [7:0]  payload_outbound = 8'h00;
    logic        pkt_ready = 1'b0;
    logic        free_outbound;
    logic [31:0] pkt_out;
    logic        pkt_valid;
    logic [3:0]  pkt_port;
    logic        framing_err;

    router_in_port #(.DEPTH(DEPTH), .PORT_ID(0)) dut (
        .clock            (clock),
        .reset            (reset),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .pkt_out          (pkt_out),
        .pkt_valid        (pkt_valid),
        .pkt_ready        (pkt_ready),
        .pkt_port         (pkt_port),
        .framing_err      (framing_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes collected so far plus a queue of whole packets.
    int          m_pos;
    logic [7:0]  m_b [3];
    logic [31:0] m_q [$];
    bit          m_free;
    bit          m_err;
    logic [31:0] m_out;
    logic [31:0] dut_pops [$];

    task automatic model_reset();
        m_pos  = 0;
        m_q.delete();
        m_free = 1'b0;
        m_err  = 1'b0;
        m_out  = '0;
    endtask

    task automatic model_edge(input bit put, input logic [7:0] b, input bit rdy);
        bit          do_pop;
        bit          have_pkt;
        logic [31:0] pkt;
        do_pop   = (m_q.size() != 0) && rdy;
        have_pkt = 1'b0;
        pkt      = '0;
        m_err    = 1'b0;
        if (m_pos == 0) begin
            if (put && m_free) begin
                m_b[0] = b;
                m_pos  = 1;
            end else if (put && ERRCHK) begin
                m_err = 1'b1;
            end
        end else if (put) begin
            if (m_pos == 3) begin
                pkt      = {m_b[0], m_b[1], m_b[2], b};
                have_pkt = 1'b1;
                m_pos    = 0;
            end else begin
                m_b[m_pos] = b;
                m_pos++;
            end
        end else if (ERRCHK) begin
            m_pos = 0;
            m_err = 1'b1;
        end
        if (do_pop) void'(m_q.pop_front());
        if (have_pkt) m_q.push_back(pkt);
        m_free = (m_pos == 0) && (m_q.size() < DEPTH);
        if (m_q.size() != 0) m_out = m_q[0];
    endtask

    task automatic compare_outputs();
        check_val("free", {31'b0, free_outbound}, {31'b0, m_free});
        check_val("valid", {31'b0, pkt_valid}, (m_q.size() != 0) ? 32'd1 : 32'd0);
        check_val("pkt_out", pkt_out, m_out);
        check_val("framing_err", {31'b0, framing_err}, {31'b0, m_err});
        check_val("pkt_port", {28'b0, pkt_port}, 32'd0);
    endtask

    // Inputs change at the falling edge; outputs are compared at the next falling edge.
    task automatic cycle(input bit put, input logic [7:0] b, input bit rdy);
        put_outbound     = put;
        payload_outbound = b;
        pkt_ready        = rdy;
        if (!reset && pkt_valid && rdy) dut_pops.push_back(pkt_out);
        @(posedge clock);
        if (reset) model_reset();
        else       model_edge(put, b, rdy);
        @(negedge clock);
        compare_outputs();
    endtask

    task automatic send_word(input logic [31:0] w, input bit rdy_last);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, w[31-8*i -: 8], (i == 3) ? rdy_last : 1'b0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && pkt_valid; i++) cycle(1'b0, 8'h00, 1'b1);
        check_val("drain_empty", {31'b0, pkt_valid}, 32'd0);
    endtask

    task automatic check_pops(input string tag, input logic [31:0] exp [$]);
        check_val({tag, "_count"}, dut_pops.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_pops.size(); i++) begin
            check_val(tag, dut_pops[i], exp[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q [$];
        model_reset();
        @(negedge clock);
        compare_outputs();
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        reset = 1'b0;
        check_val("free_at_release", {31'b0, free_outbound}, 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        check_val("free_after_release", {31'b0, free_outbound}, 32'd1);

        // single packet, held until popped
        cycle(1'b1, 8'h12, 1'b0);
        check_val("single_free_after_hdr", {31'b0, free_outbound}, 32'd0);
        cycle(1'b1, 8'h34, 1'b0);
        cycle(1'b1, 8'h56, 1'b0);
        check_val("single_no_bypass", {31'b0, pkt_valid}, 32'd0);
        cycle(1'b1, 8'h78, 1'b0);
        check_val("single_valid", {31'b0, pkt_valid}, 32'd1);
        check_val("single_out", pkt_out, 32'h12345678);
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        check_val("single_hold", pkt_out, 32'h12345678);
        cycle(1'b0, 8'h00, 1'b1);
        check_val("single_popped", {31'b0, pkt_valid}, 32'd0);
        check_val("single_out_holds", pkt_out, 32'h12345678);

        // fill to DEPTH back-to-back, then an overrun byte
        send_word(32'h12345678, 1'b0);
        send_word(32'h9ABCDEF0, 1'b0);
        send_word(32'h0FEDCBA9, 1'b0);
        send_word(32'h87654321, 1'b0);
        check_val("fill_free_full", {31'b0, free_outbound}, 32'd0);
        cycle(1'b1, 8'hCA, 1'b0);
        check_val("overrun_err", {31'b0, framing_err}, ERRCHK ? 32'd1 : 32'd0);
        check_val("overrun_free", {31'b0, free_outbound}, 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        check_val("overrun_err_clear", {31'b0, framing_err}, 32'd0);

        // drain one, refill, then drain in order
        dut_pops.delete();
        cycle(1'b0, 8'h00, 1'b1);
        check_val("refill_free", {31'b0, free_outbound}, 32'd1);
        send_word(32'hDEADBEEF, 1'b0);
        drain();
        exp_q = '{32'h12345678, 32'h9ABCDEF0, 32'h0FEDCBA9, 32'h87654321, 32'hDEADBEEF};
        check_pops("refill_order", exp_q);

        // pop coinciding with the last byte while full-minus-one
        dut_pops.delete();
        send_word(32'hA1A2A3A4, 1'b0);
        send_word(32'hB1B2B3B4, 1'b0);
        send_word(32'hC1C2C3C4, 1'b0);
        send_word(32'h01020304, 1'b1);
        check_val("sim_free", {31'b0, free_outbound}, 32'd1);
        send_word(32'h11223344, 1'b0);
        check_val("sim_full_again", {31'b0, free_outbound}, 32'd0);
        drain();
        exp_q = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'h01020304, 32'h11223344};
        check_pops("sim_order", exp_q);

        // truncated packet: put drops after byte 2
        cycle(1'b1, 8'hAB, 1'b0);
        cycle(1'b1, 8'hCD, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check_val("trunc_err", {31'b0, framing_err}, ERRCHK ? 32'd1 : 32'd0);
        check_val("trunc_free", {31'b0, free_outbound}, ERRCHK ? 32'd1 : 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h12, 1'b0);
        cycle(1'b1, 8'h34, 1'b0);
        if (!ERRCHK) begin
            check_val("trunc_resume_valid", {31'b0, pkt_valid}, 32'd1);
            check_val("trunc_resume_out", pkt_out, 32'hABCD1234);
        end else begin
            check_val("trunc_nothing_queued", {31'b0, pkt_valid}, 32'd0);
        end
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        drain();

        // reset asserted with the receiver in B2 and a packet queued
        send_word(32'h55667788, 1'b0);
        cycle(1'b1, 8'h99, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_val("rst_mid_valid", {31'b0, pkt_valid}, 32'd0);
        check_val("rst_mid_free", {31'b0, free_outbound}, 32'd0);
        check_val("rst_mid_out", pkt_out, 32'd0);
        @(negedge clock);
        cycle(1'b1, 8'hBB, 1'b0);
        reset = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        send_word(32'h13579BDF, 1'b0);
        check_val("rst_mid_clean_pkt", pkt_out, 32'h13579BDF);
        drain();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 80, 8'($urandom), $urandom_range(0, 99) < 35);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_in_port.md
Name: router_in_port

Overview:
- Router-side ingress port that terminates the node→router serial link.
- Asserts free, deserializes the 4-byte put/payload transfer into a 32-bit pkt_t, and buffers it in a packet FIFO.
- Presents buffered packets to the router core over a valid/ready interface.
- One instance per router port. Its upstream peer is the node's outbound serializer.

Parameters:
- DEPTH, 4, number of whole packets the FIFO holds (≥2).
- PORT_ID, 0, this port's id; informational only, stamped on pkt_port.

Ports:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- free_outbound  output  1  port can accept a new packet header this cycle
- put_outbound  input  1  byte-valid from node; high for 4 consecutive cycles per packet
- payload_outbound  input  8  serial byte: {src,dest}, data[23:16], data[15:8], data[7:0]
- pkt_out  output  32  head packet {src[3:0],dest[3:0],data[23:0]}
- pkt_valid  output  1  FIFO not empty
- pkt_ready  input  1  router core consumes head when pkt_valid&&pkt_ready
- pkt_port  output  4  PORT_ID, constant
- framing_err  output  1  one-cycle error pulse (see Optional Feature)

Behaviour:
- Reset, async while reset=1:
  - FIFO emptied, byte state = IDLE.
  - free_outbound=0, pkt_valid=0, pkt_out=0, framing_err=0.
  - free_outbound rises at the first clock edge after reset deasserts.
- Receive FSM states: IDLE, B1, B2, B3.
  - IDLE: at an edge with put_outbound=1 and free_outbound=1, capture payload into src/dest, go to B1. free_outbound is 0 from the next cycle.
  - B1: at an edge with put=1, capture data[23:16], go to B2.
  - B2: at an edge with put=1, capture data[15:8], go to B3.
  - B3: at an edge with put=1, capture data[7:0]. The assembled packet is written into the FIFO at that same edge. Go to IDLE.
  - Header at edge E0 → FIFO write at E3 → pkt_valid=1 in the cycle after E3. There is no combinational bypass from payload to pkt_out.
- free_outbound:
  - Registered.
  - Next value = (next_state==IDLE) && (count_next < DEPTH).
  - Back-to-back headers at E4, E8, … are accepted while space remains. This gives sustained throughput of one packet per 4 cycles.
- FIFO:
  - Show-ahead: pkt_out = head entry whenever pkt_valid=1. Holds its last value when empty.
  - Pop at an edge with pkt_valid&&pkt_ready.
  - Push and pop at the same edge: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH. count width = $clog2(DEPTH+1).
  - A full FIFO never receives a write, because free_outbound gates every header.
  - A pop at the same edge as a B3 capture frees a slot, so free_outbound=1 the next cycle.
- IDLE with put=1 and free=0: byte ignored, state unchanged.
- reset mid-packet: partial packet discarded, state IDLE.

Optional Feature:
- Macro: ROUTER_IN_PORT_ERRCHK_EN.
- Defined:
  - put_outbound=0 in B1/B2/B3 aborts the packet: bytes discarded, no FIFO write, state IDLE, framing_err=1 for one cycle.
  - put_outbound=1 in IDLE while free_outbound=0 also pulses framing_err for one cycle; the byte is ignored.
  - free_outbound is recomputed as in IDLE.
- Not defined:
  - framing_err tied 0.
  - put_outbound=0 in B1–B3 stalls: state and captured bytes held until put returns.
  - Overrun bytes are silently ignored.

Test Plan:
- Reset → free_outbound=0 during reset, 1 one cycle after release; pkt_valid=0, framing_err=0.
- Single packet:
  - Stimulus: put for 4 cycles, bytes 12,34,56,78, pkt_ready=0.
  - Required: free_outbound=0 from the cycle after the header; pkt_valid=1 the cycle after byte 4; pkt_out=32'h12345678; it stays until pkt_ready=1, then pkt_valid=0.
- Fill (DEPTH=4), pkt_ready=0:
  - Stimulus: send 12345678, 9ABCDEF0, 0FEDCBA9, 87654321 back-to-back.
  - Required: each accepted 4 cycles apart; free_outbound stays 0 after the 4th.
  - A 5th put (CAFEF00D) is ignored. With ERRCHK, framing_err pulses once.
- Drain/refill:
  - Stimulus: pop one packet, then send DEADBEEF.
  - Required: free_outbound=1 the cycle after the pop; pops in order 12345678, 9ABCDEF0, 0FEDCBA9, 87654321, DEADBEEF.
- Simultaneous events:
  - Stimulus: pkt_ready=1 while the B3 byte of 01020304 lands with the FIFO full-minus-one.
  - Required: count unchanged and the next header accepted at E4.
- Mid-packet events:
  - Truncated packet, put low after byte 2: with ERRCHK → framing_err 1 cycle, nothing queued; without → stall, then completes correctly when put resumes.
  - reset asserted in B2: FIFO empty, IDLE.
